// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one registered-address, 1-cycle-latency ROM between two
// Avalon-MM-style read ports. One read in flight at a time: accept, issue, capture.
module rom_read_arbiter #(
  parameter int unsigned width   = 8,
  parameter int unsigned widthad = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [widthad-1:0] a_address,
  input  logic               a_read,
  output logic               a_waitrequest,
  output logic [width-1:0]   a_readdata,
  output logic               a_readdatavalid,
  input  logic [widthad-1:0] b_address,
  input  logic               b_read,
  output logic               b_waitrequest,
  output logic [width-1:0]   b_readdata,
  output logic               b_readdatavalid,
  output logic [widthad-1:0] rom_addr,
  input  logic [width-1:0]   rom_q
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e state_q, state_d;
  logic   last_b_q, last_b_d;   // 1 when port b holds the most recent grant
  logic   owner_b_q, owner_b_d; // port that owns the read in flight
  logic   grant_a, grant_b;

  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    owner_b_d = owner_b_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // On a tie, the port that did not win last time gets the grant.
        if (a_read && (!b_read || last_b_q)) begin
          grant_a = 1'b1;
        end else if (b_read) begin
          grant_b = 1'b1;
        end
        if (grant_a || grant_b) begin
          state_d   = StIssue;
          owner_b_d = grant_b;
          last_b_d  = grant_b;
        end
      end
      StIssue:   state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign a_waitrequest = rst | ~grant_a;
  assign b_waitrequest = rst | ~grant_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_b_q  <= 1'b1;
      owner_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      owner_b_q <= owner_b_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
    end else if (grant_a) begin
      rom_addr <= a_address;
    end else if (grant_b) begin
      rom_addr <= b_address;
    end
  end

  // Read data holds after the pulse; only the owner's data register is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_readdata      <= '0;
      b_readdata      <= '0;
      a_readdatavalid <= 1'b0;
      b_readdatavalid <= 1'b0;
    end else begin
      a_readdatavalid <= (state_q == StCapture) && !owner_b_q;
      b_readdatavalid <= (state_q == StCapture) && owner_b_q;
      if (state_q == StCapture) begin
        if (owner_b_q) begin
          b_readdata <= rom_q;
        end else begin
          a_readdata <= rom_q;
        end
      end
    end
  end

endmodule
